// File: rtl/tri_rlmreg_pipe_p_pkg.sv
// Shared types and helpers for the tri_rlmreg_pipe_p staging pipeline.
// The cycle mode encodes the reset > scan > flush > flow ordering in one place.
package tri_rlmreg_pipe_p_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD,
        MODE_RESET,
        MODE_SCAN,
        MODE_FLUSH,
        MODE_FLOW
    } pipe_mode_e;

    // Only the low 31 bits of INIT are meaningful as a reset pattern.
    localparam logic [31:0] INIT_LS_MASK = 32'h7FFF_FFFF;

    function automatic pipe_mode_e mode_decode(
        input logic rst_b,
        input logic scan_gate,
        input logic thold_b,
        input logic act_any,
        input logic flush
    );
        pipe_mode_e mode;
        if (!rst_b) begin
            mode = MODE_RESET;
        end else if (scan_gate && thold_b) begin
            mode = MODE_SCAN;
        end else if (scan_gate || !thold_b || !act_any) begin
            mode = MODE_HOLD;
        end else if (flush) begin
            mode = MODE_FLUSH;
        end else begin
            mode = MODE_FLOW;
        end
        return mode;
    endfunction

    function automatic logic [31:0] init_ls(input int init_val);
        return 32'(init_val) & INIT_LS_MASK;
    endfunction

endpackage

// File: rtl/tri_rlmreg_pipe_p_stg.sv
// One pipeline stage: a valid bit plus a WIDTH-bit data register holding the raw
// (possibly inverted) value. Priority: reset > scan shift > load > clear > hold.
module tri_rlmreg_pipe_stg
    import tri_rlmreg_pipe_p_pkg::*;
#(
    parameter int   WIDTH  = 4,
    parameter int   OFFSET = 0,
    parameter int   INIT   = 0,
    parameter logic IBUF   = 1'b0
) (
    input  logic                         nclk,
    input  logic                         sreset_b,
    input  logic                         i_shift,
    input  logic                         i_scan_in,
    input  logic                         i_load,
    input  logic                         i_clr,
    input  logic [OFFSET:OFFSET+WIDTH-1] i_data,
    output logic                         o_val,
    output logic [OFFSET:OFFSET+WIDTH-1] o_data,
    output logic                         o_scan_out
);

    localparam logic [WIDTH-1:0] INIT_VIS = WIDTH'(init_ls(INIT));
    localparam logic [WIDTH-1:0] INIT_RAW = INIT_VIS ^ {WIDTH{IBUF}};

    logic                         r_val;
    logic [OFFSET:OFFSET+WIDTH-1] r_data;

    always_ff @(posedge nclk) begin
        if (!sreset_b) begin
            r_val  <= 1'b0;
            r_data <= INIT_RAW;
        end else if (i_shift) begin
            // Scan order inside a stage: val first, then data from OFFSET upward.
            r_val          <= i_scan_in;
            r_data[OFFSET] <= r_val;
            for (int j = 1; j < WIDTH; j++) begin
                r_data[OFFSET+j] <= r_data[OFFSET+j-1];
            end
        end else if (i_load) begin
            r_val  <= 1'b1;
            r_data <= i_data;
        end else if (i_clr) begin
            r_val  <= 1'b0;
        end
    end

    assign o_val      = r_val;
    assign o_data     = r_data;
    assign o_scan_out = r_data[OFFSET+WIDTH-1];

endmodule

// File: rtl/tri_rlmreg_pipe_p.sv
// DEPTH-stage elastic staging pipeline with valid/ready flow, bubble collapse,
// flush, act/force_t/thold_b gating and a serial scan chain through every stored bit.
module tri_rlmreg_pipe_p
    import tri_rlmreg_pipe_p_pkg::*;
#(
    parameter int   WIDTH  = 4,
    parameter int   DEPTH  = 2,
    parameter int   OFFSET = 0,
    parameter int   INIT   = 0,
    parameter logic IBUF   = 1'b0
) (
    input  logic                         nclk,
    input  logic                         sreset_b,
    inout  wire                          vd,
    inout  wire                          gd,
    input  logic                         act,
    input  logic                         force_t,
    input  logic                         thold_b,
    input  logic                         sg,
    input  logic                         scin,
    output logic                         scout,
    input  logic [OFFSET:OFFSET+WIDTH-1] din,
    input  logic                         din_val,
    output logic                         din_rdy,
    output logic [OFFSET:OFFSET+WIDTH-1] dout,
    output logic                         dout_val,
    input  logic                         dout_rdy,
    input  logic                         flush
);

    localparam logic [OFFSET:OFFSET+WIDTH-1] IBUF_MASK = {WIDTH{IBUF}};

    pipe_mode_e                   w_mode;
    logic                         w_en;
    logic                         w_shift;
    logic                         w_flow;
    logic                         w_flush;
    logic                         w_free0;
    logic [DEPTH-1:0]             w_val;
    logic [DEPTH-1:0]             w_mv;
    logic [DEPTH-1:0]             w_scan;
    logic [OFFSET:OFFSET+WIDTH-1] w_data [DEPTH];
    logic                         w_unused_pwr;

    assign w_unused_pwr = vd ^ gd;

    assign w_en    = (act | force_t) & thold_b & ~sg;
    assign w_mode  = mode_decode(sreset_b, sg, thold_b, act | force_t, flush);
    assign w_shift = (w_mode == MODE_SCAN);
    assign w_flow  = (w_mode == MODE_FLOW);
    assign w_flush = (w_mode == MODE_FLUSH);

    // Ready ripples from the consumer back to stage 0 in one cycle, so a full
    // pipe still accepts when the head is leaving.
    always_comb begin : p_ready_chain
        logic v_rdy;
        v_rdy = dout_rdy;
        w_mv  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_mv[k] = w_val[k] & v_rdy;
            v_rdy   = ~w_val[k] | v_rdy;
        end
        w_free0 = v_rdy;
    end

    assign din_rdy = w_en & ~flush & w_free0;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [OFFSET:OFFSET+WIDTH-1] w_din;
            logic                         w_sin;
            logic                         w_ld;

            if (gi == 0) begin : g_head
                assign w_din = din ^ IBUF_MASK;
                assign w_sin = scin;
                assign w_ld  = w_flow & din_val & w_free0;
            end else begin : g_body
                assign w_din = w_data[gi-1];
                assign w_sin = w_scan[gi-1];
                assign w_ld  = w_flow & w_mv[gi-1];
            end

            // A stage emptied by a move keeps its data; a refill in the same
            // cycle wins over the clear inside the stage.
            tri_rlmreg_pipe_stg #(
                .WIDTH  (WIDTH),
                .OFFSET (OFFSET),
                .INIT   (INIT),
                .IBUF   (IBUF)
            ) u_stg (
                .nclk       (nclk),
                .sreset_b   (sreset_b),
                .i_shift    (w_shift),
                .i_scan_in  (w_sin),
                .i_load     (w_ld),
                .i_clr      (w_flush | (w_flow & w_mv[gi])),
                .i_data     (w_din),
                .o_val      (w_val[gi]),
                .o_data     (w_data[gi]),
                .o_scan_out (w_scan[gi])
            );
        end
    endgenerate

    assign dout     = w_data[DEPTH-1] ^ IBUF_MASK;
    assign dout_val = w_val[DEPTH-1];
    assign scout    = w_scan[DEPTH-1];

endmodule

// File: tb/tb_tri_rlmreg_pipe_p.sv
// Scoreboard bench for tri_rlmreg_pipe_p (WIDTH=8, DEPTH=3, OFFSET=2, INIT=A5, IBUF=1).
// The reference treats the pipe as an ordered list of at most DEPTH entries.
module tb_tri_rlmreg_pipe_p;

    localparam int W   = 8;
    localparam int D   = 3;
    localparam int OFF = 2;
    localparam logic [7:0] INIT_V = 8'hA5;

    logic nclk = 1'b0;
    always #5 nclk = ~nclk;

    logic             sreset_b, act, force_t, thold_b, sg, scin;
    logic             din_val, dout_rdy, flush;
    logic [OFF:OFF+W-1] din;
    logic             scout, din_rdy, dout_val;
    logic [OFF:OFF+W-1] dout;
    logic [7:0]       dout_bits;
    wire              vd = 1'b1;
    wire              gd = 1'b0;

    assign dout_bits = dout;

    tri_rlmreg_pipe_p #(
        .WIDTH(W), .DEPTH(D), .OFFSET(OFF), .INIT(32'hA5), .IBUF(1'b1)
    ) dut (
        .nclk(nclk), .sreset_b(sreset_b), .vd(vd), .gd(gd),
        .act(act), .force_t(force_t), .thold_b(thold_b), .sg(sg),
        .scin(scin), .scout(scout),
        .din(din), .din_val(din_val), .din_rdy(din_rdy),
        .dout(dout), .dout_val(dout_val), .dout_rdy(dout_rdy),
        .flush(flush)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    logic       n_srst = 1'b0, n_act = 1'b1, n_force = 1'b0, n_thold = 1'b1, n_sg = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic en_now();
        return (act | force_t) & thold_b & ~sg;
    endfunction

    // One flow cycle: drive at negedge, then predict readiness and acceptance.
    task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
        logic exp_rdy;
        @(negedge nclk);
        sreset_b = n_srst; act = n_act; force_t = n_force; thold_b = n_thold; sg = n_sg;
        din_val = v; din = d; dout_rdy = rdy; flush = fl;
        #1;
        if (!sreset_b) begin
            sb.delete();
        end else if (!sg) begin
            exp_rdy = en_now() & ~fl & ((sb.size() < D) | rdy);
            chk("din_rdy", 32'(din_rdy), 32'(exp_rdy));
            if (en_now() && fl) sb.delete();
            else if (v && exp_rdy) sb.push_back(d);
        end
    endtask

    task automatic scan_cyc(input logic b, output logic so);
        @(negedge nclk);
        sreset_b = 1'b1; thold_b = 1'b1; sg = 1'b1; din_val = 1'b0; flush = 1'b0; scin = b;
        #1;
        so = scout;
    endtask

    // Monitor: pops the oldest expected entry whenever a dout transfer will occur.
    initial begin
        logic [7:0] dexp;
        forever begin
            @(negedge nclk);
            #2;
            if (sreset_b && !sg && !(en_now() && flush) && dout_val) begin
                chk("val_has_data", 32'(sb.size() != 0), 32'd1);
                if (en_now() && dout_rdy && sb.size() != 0) begin
                    dexp = sb.pop_front();
                    chk("dout_data", 32'(dout_bits), 32'(dexp));
                end
            end
        end
    end

    initial begin
        logic [26:0] ch;
        logic [7:0]  raw;
        logic        so, b;
        int          acc;
        logic [7:0]  snap_d;
        logic        snap_v;
        logic        stream_exp [7];

        sreset_b = 1'b0; act = 1'b1; force_t = 1'b0; thold_b = 1'b1; sg = 1'b0;
        scin = 1'b0; din = '0; din_val = 1'b0; dout_rdy = 1'b0; flush = 1'b0;

        // Reset state
        n_srst = 1'b0;
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        n_srst = 1'b1;
        cyc(0, 8'h00, 1, 0);
        chk("rst_dout", 32'(dout_bits), 32'(INIT_V));
        chk("rst_val", 32'(dout_val), 32'd0);
        chk("rst_rdy", 32'(din_rdy), 32'd1);

        // Scan chain: 27 bits of ~INIT, then the 27 random bits shifted in
        raw = ~INIT_V;
        for (int k = 0; k < D; k++) begin
            ch[k*9] = 1'b0;
            for (int j = 0; j < W; j++) ch[k*9+1+j] = raw[7-j];
        end
        for (int s = 0; s < 54; s++) begin
            b = 1'($urandom);
            scan_cyc(b, so);
            chk("scout", 32'(so), 32'(ch[26]));
            ch = {ch[25:0], b};
        end
        n_srst = 1'b0; n_sg = 1'b1;
        cyc(0, 8'h00, 0, 0);
        n_srst = 1'b1; n_sg = 1'b0;
        cyc(0, 8'h00, 1, 0);
        chk("rst_in_scan_dout", 32'(dout_bits), 32'(INIT_V));
        chk("rst_in_scan_val", 32'(dout_val), 32'd0);

        // Streaming latency and order
        stream_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            cyc(i < 3, 8'(i + 1), 1, 0);
            if (i >= 1) chk("stream_val", 32'(dout_val), 32'(stream_exp[i]));
            if (i >= 3 && i <= 5) chk("stream_dout", 32'(dout_bits), 32'(i - 2));
        end

        // Back-pressure: exactly DEPTH entries accepted, then full-rate refill
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'(8'h40 + i), 0, 0);
            acc += int'(din_rdy);
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        chk("bp_rdy_low", 32'(din_rdy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'(8'h50 + i), 1, 0);
            chk("refill_rdy", 32'(din_rdy), 32'd1);
        end
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0);
        chk("drain_val", 32'(dout_val), 32'd0);

        // Bubble collapse
        cyc(1, 8'h10, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h20, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("bubble_rdy", 32'(din_rdy), 32'd1);
        chk("bubble_val", 32'(dout_val), 32'd1);
        chk("bubble_head", 32'(dout_bits), 32'h10);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("bubble_next_val", 32'(dout_val), 32'd1);
        chk("bubble_next", 32'(dout_bits), 32'h20);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);

        // Flush on a full pipe with traffic offered
        cyc(1, 8'h31, 0, 0);
        cyc(1, 8'h32, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(0, 8'h00, 0, 0);
        chk("pre_flush_dout", 32'(dout_bits), 32'h31);
        cyc(1, 8'h99, 1, 1);
        cyc(1, 8'h77, 1, 0);
        chk("flush_val", 32'(dout_val), 32'd0);
        chk("flush_data_held", 32'(dout_bits), 32'h31);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("post_flush_val", 32'(dout_val), 32'd1);
        chk("post_flush_dout", 32'(dout_bits), 32'h77);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);

        // Gating: thold_b=0, then act=force_t=0, freeze everything
        cyc(1, 8'h51, 0, 0);
        cyc(1, 8'h52, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        snap_d = dout_bits;
        snap_v = dout_val;
        chk("gate_pre_dout", 32'(snap_d), 32'h51);
        n_thold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'($urandom), 1, 1'($urandom));
            chk("thold_dout", 32'(dout_bits), 32'(snap_d));
            chk("thold_val", 32'(dout_val), 32'(snap_v));
        end
        n_thold = 1'b1; n_act = 1'b0; n_force = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'($urandom), 1, 1'($urandom));
            chk("act_dout", 32'(dout_bits), 32'(snap_d));
            chk("act_val", 32'(dout_val), 32'(snap_v));
        end
        n_force = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0);
        n_act = 1'b1; n_force = 1'b0;
        cyc(1, 8'h61, 0, 0);
        cyc(0, 8'h00, 0, 0);
        n_thold = 1'b0; n_srst = 1'b0;
        cyc(0, 8'h00, 0, 0);
        n_thold = 1'b1; n_srst = 1'b1;
        cyc(0, 8'h00, 1, 0);
        chk("thold_rst_val", 32'(dout_val), 32'd0);
        chk("thold_rst_dout", 32'(dout_bits), 32'(INIT_V));

        // Randomized traffic with gating and flushes
        for (int i = 0; i < 400; i++) begin
            n_act   = ($urandom % 10) != 0;
            n_force = ($urandom % 8) == 0;
            n_thold = ($urandom % 12) != 0;
            cyc(($urandom % 3) != 0, 8'($urandom), ($urandom % 4) != 0, ($urandom % 25) == 0);
        end
        n_act = 1'b1; n_force = 1'b0; n_thold = 1'b1;
        for (int i = 0; i < 6; i++) cyc(0, 8'h00, 1, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("final_val", 32'(dout_val), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
